// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the RV32M divide sequencer: op encodings, FSM states, default width.
package div_sequencer_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide iteration: shift in the next dividend bit, trial subtract.
module div_step
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             msb_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // rem_in < divisor always holds, so the borrow bit of the WIDTH+1 difference is the sign.
  always_comb begin
    rem_sh  = {rem_in, msb_in};
    diff    = rem_sh - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  end

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: stalls EX while a restoring divide iterates, then pulses done.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [1:0]       divOp,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  div_op_e          op_q, op_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             in_signed;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic             div_zero, sgn_ovf;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] q_fin, q_fix, r_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .divisor (dvsr_q),
    .msb_in  (quo_q[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  // Operand preparation and special-case detection for the incoming op.
  always_comb begin
    in_signed = ~divOp[0];
    dvd_neg   = in_signed & dividend[WIDTH-1];
    dvs_neg   = in_signed & divisor[WIDTH-1];
    dvd_abs   = dvd_neg ? (WIDTH'(0) - dividend) : dividend;
    dvs_abs   = dvs_neg ? (WIDTH'(0) - divisor) : divisor;
    div_zero  = (divisor == '0);
    sgn_ovf   = in_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
  end

  // Final step's quotient/remainder with sign fix-up for signed ops.
  always_comb begin
    q_fin = {quo_q[WIDTH-2:0], step_qbit};
    q_fix = (op_is_signed(op_q) && neg_q_q) ? (WIDTH'(0) - q_fin) : q_fin;
    r_fix = (op_is_signed(op_q) && neg_r_q) ? (WIDTH'(0) - step_rem) : step_rem;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    op_d     = op_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          op_d    = div_op_e'(divOp);
          neg_q_d = dvd_neg ^ dvs_neg;
          neg_r_d = dvd_neg;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = dvd_abs;
          dvsr_d  = dvs_abs;
          if (div_zero) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = divOp[1] ? dividend : '1;
          end else if (sgn_ovf) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = divOp[1] ? '0 : dividend;
          end else begin
            state_d = ST_CALC;
            busy_d  = 1'b1;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = q_fin;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = op_is_rem(op_q) ? r_fix : q_fix;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      op_q     <= DIV_OP_DIV;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      op_q     <= op_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign stall  = ((state_q == ST_IDLE) && start && !flush) || (state_q == ST_CALC);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: expected result and completion cycle queued at issue.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rstN;
  logic         start;
  logic [1:0]   divOp;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  div_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .start    (start),
    .divOp    (divOp),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int unsigned  due;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    if (b == '0) return op[1] ? a : '1;
    if (!op[0] && a == 32'h8000_0000 && b == '1) return op[1] ? '0 : a;
    if (!op[0]) return op[1] ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Completion monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rstN === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", W'(1), W'(0));
      end else begin
        e = sb.pop_front();
        check({e.tag, "_res"}, result, e.res);
        check({e.tag, "_cyc"}, W'(cyc), W'(e.due));
      end
    end
  end

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input bit normal);
    int unsigned t0;
    int unsigned k;
    int unsigned rel;
    @(negedge clk);
    start    = 1'b1;
    divOp    = op;
    dividend = a;
    divisor  = b;
    t0       = cyc;
    sb.push_back('{exp, t0 + (normal ? 33 : 1), tag});
    #1 check({tag, "_stall_accept"}, W'(stall), W'(1));
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      rel = cyc - t0;
      check({tag, "_busy"}, W'(busy), W'(normal && rel >= 1 && rel <= 32));
      check({tag, "_stall"}, W'(stall), W'(normal && rel >= 1 && rel <= 32));
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check({tag, "_timeout"}, W'(0), W'(1));
      sb.delete();
    end
  endtask

  initial begin
    int unsigned t0;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    rstN     = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    divOp    = 2'b00;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_stall", W'(stall), W'(0));
    check("rst_result", result, W'(0));
    rstN = 1'b1;
    @(negedge clk);

    run_op("divu_100_7",  2'b01, 32'd100, 32'd7, 32'd14, 1'b1);
    run_op("remu_100_7",  2'b11, 32'd100, 32'd7, 32'd2, 1'b1);
    run_op("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    run_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    run_op("rem_7_m2",    2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b1);
    run_op("div_5_0",     2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("remu_5_0",    2'b11, 32'd5, 32'd0, 32'd5, 1'b0);
    run_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("divu_no_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    run_op("divu_big",    2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 1'b1);
    run_op("remu_big",    2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b1);

    // Flush mid-CALC: no done, result retains the previous completion.
    @(negedge clk);
    start    = 1'b1;
    divOp    = 2'b01;
    dividend = 32'd1000;
    divisor  = 32'd3;
    t0       = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 10) @(negedge clk);
    check("flush_busy_before", W'(busy), W'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", W'(busy), W'(0));
    check("flush_stall_after", W'(stall), W'(0));
    check("flush_result_kept", result, 32'h7FFF_FFFE);
    repeat (40) @(negedge clk);
    check("flush_result_still", result, 32'h7FFF_FFFE);

    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 1'b1);

    // Asynchronous reset during CALC discards the operation.
    @(negedge clk);
    start    = 1'b1;
    divOp    = 2'b01;
    dividend = 32'd1000;
    divisor  = 32'd7;
    t0       = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 5) @(negedge clk);
    rstN = 1'b0;
    #1;
    check("arst_busy", W'(busy), W'(0));
    check("arst_stall", W'(stall), W'(0));
    check("arst_done", W'(done), W'(0));
    check("arst_result", result, W'(0));
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);

    // start with flush in IDLE is ignored.
    start    = 1'b1;
    flush    = 1'b1;
    divOp    = 2'b01;
    dividend = 32'd50;
    divisor  = 32'd5;
    #1 check("sf_stall", W'(stall), W'(0));
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("sf_busy", W'(busy), W'(0));
    repeat (3) @(negedge clk);
    check("sf_result", result, W'(0));

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      if (i == 0) rb = '0;
      run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb),
             !(rb == '0 || (!rop[0] && ra == 32'h8000_0000 && rb == '1)));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle sequencer for RV32M divide/remainder (DIV, DIVU, REM, REMU), sitting in the Execute stage beside the single-cycle ALU.
- Accepts an operation from the EX pipeline register, stalls the pipeline while a radix-2 restoring divide iterates, then presents a registered result with a one-cycle done pulse.
- Owns the divide FSM, the iteration counter, sign fix-up and the RISC-V special cases (divide-by-zero, signed overflow).

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rstN  input  1  reset, asynchronous, active-low.
start  input  1  EX-stage instruction is a divide op; sampled only in IDLE.
divOp  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
dividend  input  WIDTH  rs1 value; sampled with start.
divisor  input  WIDTH  rs2 value; sampled with start.
flush  input  1  branch/jump flush from EX; aborts operation.
stall  output  1  hold IF/ID/EX; combinational.
busy  output  1  high in CALC; registered.
done  output  1  one-cycle pulse, result valid.
result  output  WIDTH  quotient or remainder; registered, held until next completion.

Behaviour:
- Reset (rstN low, asynchronous): state IDLE, counter 0, busy 0, done 0, result 0, internal quotient/remainder/operand registers 0. Reset mid-CALC discards the operation with no done pulse.
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1, flush=0:
  - Latch divOp and operand magnitudes. Signed ops take absolute values; record negQ = sign(dividend) XOR sign(divisor) and negR = sign(dividend).
  - Divisor == 0: next state DONE. Quotient = all ones; remainder = raw dividend.
  - Signed op with dividend = 0x80000000 and divisor = 0xFFFFFFFF: next state DONE. Quotient = 0x80000000; remainder = 0.
  - Otherwise: next state CALC, counter = 0.
- IDLE, flush=1: stays IDLE; flush has priority over start.
- CALC, one restoring step per cycle:
  - Shift the remainder/quotient pair left one bit.
  - Trial subtract the divisor; if the result is non-negative, keep it and set quotient bit 0.
  - Counter increments each step; after step WIDTH-1 (counter = WIDTH-1), next state is DONE.
- CALC, flush=1: next state IDLE. Partial results are discarded, result is unchanged, no done pulse.
- Entering DONE: result loads the quotient (DIV/DIVU) or remainder (REM/REMU). For signed ops the quotient is negated if negQ and the remainder is negated if negR; special cases are not fixed up.
- DONE: done=1 for exactly one cycle, then unconditional transition to IDLE. start is ignored in DONE because the pipeline advances this cycle. flush in DONE has no effect on done or result.
- stall = (IDLE & start & ~flush) | CALC. stall is low in DONE.
- Latency, start accepted at cycle T:
  - Normal case: CALC occupies T+1..T+32, done at T+33 (WIDTH+1 cycles after T).
  - Special case: done at T+1.
- Back-to-back divides: the second start is seen in IDLE at T+34 at the earliest. No overlap.
- All arithmetic uses unsigned WIDTH bits, with a WIDTH+1-bit trial subtraction. Counter width is clog2(WIDTH).

Decomposition:
- Shared package: divOp encodings (DIV, DIVU, REM, REMU), FSM state encoding (IDLE, CALC, DONE), WIDTH default. The existing ALU operation constants remain the single source for ALU codes.
- One natural sub-module: div_step, a combinational single restoring iteration (remainder in, divisor, dividend MSB in -> remainder out, quotient bit). The sequencer instantiates it once.

Test Plan:
- DIVU 100/7 at cycle T -> stall high T..T+32, busy high T+1..T+32, done at T+33, result 14. REMU on the same operands -> result 2.
- DIV -7/2 -> result 0xFFFFFFFD (-3). REM -7/2 -> result 0xFFFFFFFF (-1). REM 7/-2 -> result 1.
- DIV 5/0 -> done at T+1, result 0xFFFFFFFF. REMU 5/0 -> result 5. busy never asserted.
- DIV 0x80000000/0xFFFFFFFF -> done at T+1, result 0x80000000. REM on the same operands -> result 0.
- DIVU 1000/3, flush pulsed at T+10 -> stall and busy low from T+11, no done pulse, result keeps its previous value. Next DIVU 9/3 completes with result 3.
- rstN driven low at T+5 during CALC -> busy, stall, done and result all 0 immediately. After release, an idle start-free cycle produces no done. start with flush=1 in IDLE -> no stall, state stays IDLE.
